// File: rtl/shift_sub_divider_if.sv
// ---------------------------------------------------------------------------
// shift_sub_divider_if
//   Board-side bundle for the 8-bit shift/subtract divider.
//
//   run            : start a division (level, debounced upstream)
//   clear_a_load_b : A <= 0, B <= switches (dividend load)
//   switches[7:0]  : dividend source on load, divisor source on run
//   aval[7:0]      : register A (partial / final remainder)
//   bval[7:0]      : register B (dividend before, quotient after)
//   div_zero       : divisor latched at run was zero
//   busy           : division in progress
//   done           : result is valid and holding
//
//   master : the board / testbench side that drives the controls
//   slave  : the divider itself
// ---------------------------------------------------------------------------
interface shift_sub_divider_if;
  logic       run;
  logic       clear_a_load_b;
  logic [7:0] switches;
  logic [7:0] aval;
  logic [7:0] bval;
  logic       div_zero;
  logic       busy;
  logic       done;

  modport master (
    output run, clear_a_load_b, switches,
    input  aval, bval, div_zero, busy, done
  );

  modport slave (
    input  run, clear_a_load_b, switches,
    output aval, bval, div_zero, busy, done
  );
endinterface

// File: rtl/shift_sub_divider.sv
// ---------------------------------------------------------------------------
// shift_sub_divider
//   Sequential 8-bit unsigned restoring divider. The dividend is loaded into
//   B, the divisor is captured into D when run is seen, and eight
//   shift/subtract pairs leave the quotient in B and the remainder in A.
//
//   clk   : system clock, all state changes on the rising edge
//   reset : synchronous, active-high; clears A, B, D, cnt, div_zero, state
//   bus   : shift_sub_divider_if.slave (controls in, A/B/status out)
// ---------------------------------------------------------------------------
module shift_sub_divider (
  input  logic                  clk,
  input  logic                  reset,
  shift_sub_divider_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    SUB   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] a_reg;
  logic [7:0] b_reg;
  logic [7:0] d_reg;
  logic [2:0] cnt;
  logic       div_zero_reg;

  // Nine-bit subtract: bit 8 is the borrow, set when A < D.
  logic [8:0] diff;
  assign diff = {1'b0, a_reg} - {1'b0, d_reg};

  // Single controller/datapath process. Load has priority over run in IDLE
  // and DONE; controls are ignored while the division is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      a_reg        <= 8'h00;
      b_reg        <= 8'h00;
      d_reg        <= 8'h00;
      cnt          <= 3'd0;
      div_zero_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clear_a_load_b) begin
            a_reg        <= 8'h00;
            b_reg        <= bus.switches;
            div_zero_reg <= 1'b0;
          end else if (bus.run) begin
            if (bus.switches == 8'h00) begin
              // Divide by zero: show the dividend in A and all-ones in B.
              div_zero_reg <= 1'b1;
              a_reg        <= b_reg;
              b_reg        <= 8'hFF;
              state        <= DONE;
            end else begin
              d_reg        <= bus.switches;
              a_reg        <= 8'h00;
              cnt          <= 3'd0;
              div_zero_reg <= 1'b0;
              state        <= SHIFT;
            end
          end
        end

        SHIFT: begin
          {a_reg, b_reg} <= {a_reg, b_reg} << 1;
          state          <= SUB;
        end

        SUB: begin
          // Restoring step: keep the difference only when no borrow occurred.
          if (!diff[8]) begin
            a_reg    <= diff[7:0];
            b_reg[0] <= 1'b1;
          end
          if (cnt == 3'd7) begin
            state <= DONE;
          end else begin
            cnt   <= cnt + 3'd1;
            state <= SHIFT;
          end
        end

        DONE: begin
          // Run must drop before another division can start.
          if (bus.clear_a_load_b) begin
            a_reg        <= 8'h00;
            b_reg        <= bus.switches;
            div_zero_reg <= 1'b0;
            state        <= IDLE;
          end else if (!bus.run) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.aval     = a_reg;
  assign bus.bval     = b_reg;
  assign bus.div_zero = div_zero_reg;
  assign bus.busy     = (state == SHIFT) || (state == SUB);
  assign bus.done     = (state == DONE);

endmodule

// File: tb/tb_shift_sub_divider.sv
// ---------------------------------------------------------------------------
// tb_shift_sub_divider
//   Directed bench for shift_sub_divider. A behavioural model tracks the
//   board-visible result (quotient = dividend / divisor, remainder =
//   dividend % divisor, a 16-cycle busy window) and a compare process checks
//   the DUT against it on every falling edge. Literal expectations for the
//   directed cases pin the model.
// ---------------------------------------------------------------------------
module tb_shift_sub_divider;

  logic clk;
  logic reset;

  shift_sub_divider_if bus ();

  shift_sub_divider dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int checks;
  int errors;
  bit compare_en;

  // Behavioural model: only three phases matter to the board.
  typedef enum {M_IDLE, M_BUSY, M_DONE} m_phase_t;
  m_phase_t   m_phase;
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic       m_dz;
  logic [7:0] m_dividend;
  logic [7:0] m_divisor;
  int         m_left;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = M_IDLE;
      m_a     = 8'h00;
      m_b     = 8'h00;
      m_dz    = 1'b0;
      m_left  = 0;
    end else begin
      case (m_phase)
        M_IDLE: begin
          if (bus.clear_a_load_b) begin
            m_a  = 8'h00;
            m_b  = bus.switches;
            m_dz = 1'b0;
          end else if (bus.run) begin
            if (bus.switches == 8'h00) begin
              m_dz    = 1'b1;
              m_a     = m_b;
              m_b     = 8'hFF;
              m_phase = M_DONE;
            end else begin
              m_dividend = m_b;
              m_divisor  = bus.switches;
              m_dz       = 1'b0;
              m_left     = 16;
              m_phase    = M_BUSY;
            end
          end
        end
        M_BUSY: begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_b     = m_dividend / m_divisor;
            m_a     = m_dividend % m_divisor;
            m_phase = M_DONE;
          end
        end
        M_DONE: begin
          if (bus.clear_a_load_b) begin
            m_a     = 8'h00;
            m_b     = bus.switches;
            m_dz    = 1'b0;
            m_phase = M_IDLE;
          end else if (!bus.run) begin
            m_phase = M_IDLE;
          end
        end
        default: m_phase = M_IDLE;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    if (compare_en) begin
      checkOutput("cyc_busy", {7'd0, bus.busy}, {7'd0, m_phase == M_BUSY});
      checkOutput("cyc_done", {7'd0, bus.done}, {7'd0, m_phase == M_DONE});
      checkOutput("cyc_divzero", {7'd0, bus.div_zero}, {7'd0, m_dz});
      if (m_phase != M_BUSY) begin
        checkOutput("cyc_aval", bus.aval, m_a);
        checkOutput("cyc_bval", bus.bval, m_b);
      end
    end
  end

  task automatic applyStimulus(input logic clr, input logic run_in, input logic [7:0] sw);
    bus.clear_a_load_b = clr;
    bus.run            = run_in;
    bus.switches       = sw;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start a division (edge 0), then wait for done with a bounded budget
  // and check the latency.
  task automatic runDivision(input string name, input logic [7:0] dividend,
                             input logic [7:0] divisor);
    int n;
    applyStimulus(1'b1, 1'b0, dividend);
    tick(1);
    checkOutput({name, "_load_b"}, bus.bval, dividend);
    applyStimulus(1'b0, 1'b1, divisor);
    tick(1);
    checkOutput({name, "_busy0"}, {7'd0, bus.busy}, 8'd1);
    n = 0;
    while (!bus.done && n < 40) begin
      tick(1);
      n++;
    end
    checkOutput({name, "_latency"}, n[7:0], 8'd16);
  endtask

  initial begin
    int starts;
    logic prev_busy;
    checks     = 0;
    errors     = 0;
    compare_en = 1'b0;
    reset      = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick(2);
    checkOutput("reset_aval", bus.aval, 8'h00);
    checkOutput("reset_bval", bus.bval, 8'h00);
    checkOutput("reset_busy", {7'd0, bus.busy}, 8'd0);
    checkOutput("reset_done", {7'd0, bus.done}, 8'd0);
    checkOutput("reset_dz", {7'd0, bus.div_zero}, 8'd0);
    reset      = 1'b0;
    compare_en = 1'b1;
    tick(1);

    // 200 / 7 = 28 r 4
    runDivision("d200_7", 8'hC8, 8'h07);
    checkOutput("d200_7_q", bus.bval, 8'h1C);
    checkOutput("d200_7_r", bus.aval, 8'h04);
    checkOutput("d200_7_dz", {7'd0, bus.div_zero}, 8'd0);
    checkOutput("d200_7_model", m_b, 8'h1C);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick(2);

    // 255 / 1 = 255 r 0
    runDivision("d255_1", 8'hFF, 8'h01);
    checkOutput("d255_1_q", bus.bval, 8'hFF);
    checkOutput("d255_1_r", bus.aval, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick(2);

    // 5 / 9 = 0 r 5
    runDivision("d5_9", 8'h05, 8'h09);
    checkOutput("d5_9_q", bus.bval, 8'h00);
    checkOutput("d5_9_r", bus.aval, 8'h05);
    checkOutput("d5_9_model", m_a, 8'h05);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick(2);

    // Divide by zero: one cycle, busy never asserts
    applyStimulus(1'b1, 1'b0, 8'h2A);
    tick(1);
    applyStimulus(1'b0, 1'b1, 8'h00);
    tick(1);
    checkOutput("dz_done", {7'd0, bus.done}, 8'd1);
    checkOutput("dz_busy", {7'd0, bus.busy}, 8'd0);
    checkOutput("dz_flag", {7'd0, bus.div_zero}, 8'd1);
    checkOutput("dz_q", bus.bval, 8'hFF);
    checkOutput("dz_r", bus.aval, 8'h2A);
    applyStimulus(1'b1, 1'b0, 8'h11);
    tick(1);
    checkOutput("dz_cleared", {7'd0, bus.div_zero}, 8'd0);
    checkOutput("dz_reload", bus.bval, 8'h11);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick(1);

    // Reset in the middle of a division
    applyStimulus(1'b1, 1'b0, 8'hC8);
    tick(1);
    applyStimulus(1'b0, 1'b1, 8'h07);
    tick(6);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    checkOutput("mid_rst_aval", bus.aval, 8'h00);
    checkOutput("mid_rst_bval", bus.bval, 8'h00);
    checkOutput("mid_rst_busy", {7'd0, bus.busy}, 8'd0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick(4);
    checkOutput("post_rst_bval", bus.bval, 8'h00);
    checkOutput("post_rst_done", {7'd0, bus.done}, 8'd0);

    // Run held high for 40 cycles with a load pulse while busy
    applyStimulus(1'b1, 1'b0, 8'hC8);
    tick(1);
    applyStimulus(1'b0, 1'b1, 8'h07);
    starts    = 0;
    prev_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 5)  applyStimulus(1'b1, 1'b1, 8'h55);
      if (i == 6)  applyStimulus(1'b0, 1'b1, 8'h07);
      tick(1);
      if (bus.busy && !prev_busy) starts++;
      prev_busy = bus.busy;
    end
    checkOutput("held_starts", starts[7:0], 8'd1);
    checkOutput("held_q", bus.bval, 8'h1C);
    checkOutput("held_r", bus.aval, 8'h04);
    checkOutput("held_done", {7'd0, bus.done}, 8'd1);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick(2);

    // Load and run together: load wins, division starts next cycle
    applyStimulus(1'b1, 1'b1, 8'h30);
    tick(1);
    checkOutput("both_aval", bus.aval, 8'h00);
    checkOutput("both_bval", bus.bval, 8'h30);
    checkOutput("both_busy", {7'd0, bus.busy}, 8'd0);
    applyStimulus(1'b0, 1'b1, 8'h06);
    tick(1);
    checkOutput("both_start", {7'd0, bus.busy}, 8'd1);
    tick(16);
    checkOutput("both_q", bus.bval, 8'h08);
    checkOutput("both_r", bus.aval, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    tick(2);

    compare_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
